carrier_loop_filter: RTL

- Second-order PI loop filter for the carrier tracking loop, one instance per tracking channel.
- Consumes one discriminator error per integration epoch (1 ms typ.) from the correlator/discriminator stage.
- Produces the signed frequency control word that drives the carrier NCO's `correction` input.
- Holds the integrator state, saturates all arithmetic, and presents a registered, held output between updates.

---
 rtl/carrier_loop_filter.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/carrier_loop_filter.sv
// carrier_loop_filter: second-order PI loop filter for one carrier tracking channel.
// Takes one discriminator error per epoch and produces the saturated NCO frequency
// control word FCW_NOM + integrator + proportional term, held between updates.
// Each update walks IDLE -> MUL -> ACC -> OUT. The new word appears in OUT, three
// cycles after the disc_valid cycle.
// Optional lock detector: define CARRIER_LOOP_FILTER_LOCK_DET_EN to add the `locked`
// output and its consecutive-epoch counter.
module carrier_loop_filter #(
    parameter int          ERR_W    = 16,
    parameter int          SHIFT    = 8,
    parameter logic [31:0] FCW_NOM  = 32'h1000_0000,
    parameter logic [31:0] INT_LIM  = 32'h3FFF_FFFF
`ifdef CARRIER_LOOP_FILTER_LOCK_DET_EN
    ,
    parameter logic [15:0] LOCK_THR = 16'd512,
    parameter logic [7:0]  LOCK_CNT = 8'd20
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disc_valid,
    input  logic [ERR_W-1:0] disc_err,
    input  logic [ERR_W-1:0] kp,
    input  logic [ERR_W-1:0] ki,
    input  logic             freeze,
    input  logic             clr_int,
    output logic [31:0]      correction,
    output logic             corr_valid,
    output logic             busy,
    output logic             overrun
`ifdef CARRIER_LOOP_FILTER_LOCK_DET_EN
    ,
    output logic             locked
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam int PW = 2 * ERR_W;
    localparam logic signed [33:0] MAX32_C = 34'sh0_7FFF_FFFF;
    localparam logic signed [33:0] MIN32_C = 34'sh3_8000_0000;

    // Clamp to the symmetric range [-lim, +lim].
    function automatic logic signed [33:0] sat_sym(input logic signed [33:0] v,
                                                   input logic signed [33:0] lim);
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end else begin
            return v;
        end
    endfunction

    // Clamp to the full two's-complement 32-bit range.
    function automatic logic [31:0] sat32(input logic signed [33:0] v);
        if (v > MAX32_C) begin
            return 32'h7FFF_FFFF;
        end else if (v < MIN32_C) begin
            return 32'h8000_0000;
        end else begin
            return v[31:0];
        end
    endfunction

    state_t                   state_q, state_d;
    logic signed [ERR_W-1:0]  err_q, err_d, kp_q, kp_d, ki_q, ki_d;
    logic signed [33:0]       p_q, p_d, i_q, i_d;
    logic signed [31:0]       integ_q, integ_d;
    logic [31:0]              corr_q, corr_d;
    logic                     corr_valid_q, corr_valid_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;

    logic signed [PW-1:0]     prod_p_s, prod_i_s, shp_s, shi_s;
    logic signed [33:0]       integ_sum_s, corr_sum_s, lim_s;

    assign prod_p_s = err_q * kp_q;
    assign prod_i_s = err_q * ki_q;
    assign shp_s    = prod_p_s >>> SHIFT;
    assign shi_s    = prod_i_s >>> SHIFT;
    assign lim_s    = {2'b00, INT_LIM};

`ifdef CARRIER_LOOP_FILTER_LOCK_DET_EN
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        locked_q, locked_d;
    logic [31:0] err_ext_s, err_mag_s;
    logic        in_thr_s;

    assign err_ext_s = {{(32 - ERR_W){err_q[ERR_W-1]}}, err_q};
    assign err_mag_s = err_ext_s[31] ? (32'd0 - err_ext_s) : err_ext_s;
    assign in_thr_s  = (err_mag_s <= {16'd0, LOCK_THR});
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: fixed four-cycle walk started by an accepted sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (disc_valid) begin
                    state_d = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL:   state_d = S_ACC;
            S_ACC:   state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values for each state.
    always_comb begin
        err_d        = err_q;
        kp_d         = kp_q;
        ki_d         = ki_q;
        p_d          = p_q;
        i_d          = i_q;
        integ_d      = integ_q;
        corr_d       = corr_q;
        corr_valid_d = 1'b0;
        busy_d       = (state_d != S_IDLE);
        overrun_d    = disc_valid && (state_q != S_IDLE);
        integ_sum_s  = {{2{integ_q[31]}}, integ_q} + i_q;
        corr_sum_s   = 34'sd0;
`ifdef CARRIER_LOOP_FILTER_LOCK_DET_EN
        lock_cnt_d   = lock_cnt_q;
        locked_d     = locked_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (disc_valid) begin
                    err_d = disc_err;
                    kp_d  = kp;
                    ki_d  = ki;
                end else begin
                    err_d = err_q;
                end
                if (clr_int) begin
                    integ_d = 32'sd0;
`ifdef CARRIER_LOOP_FILTER_LOCK_DET_EN
                    lock_cnt_d = 8'd0;
                    locked_d   = 1'b0;
`endif
                end else begin
                    integ_d = integ_q;
                end
            end
            S_MUL: begin
                p_d = {{(34 - PW){shp_s[PW-1]}}, shp_s};
                i_d = {{(34 - PW){shi_s[PW-1]}}, shi_s};
            end
            S_ACC: begin
                // clr_int outranks freeze, which outranks accumulation
                if (clr_int) begin
                    integ_d = 32'sd0;
                end else if (freeze) begin
                    integ_d = integ_q;
                end else begin
                    integ_d = 32'(sat_sym(integ_sum_s, lim_s));
                end
                corr_sum_s   = {{2{FCW_NOM[31]}}, FCW_NOM}
                             + {{2{integ_d[31]}}, integ_d} + p_q;
                corr_d       = sat32(corr_sum_s);
                corr_valid_d = 1'b1;
`ifdef CARRIER_LOOP_FILTER_LOCK_DET_EN
                if (clr_int || !in_thr_s) begin
                    lock_cnt_d = 8'd0;
                    locked_d   = 1'b0;
                end else begin
                    lock_cnt_d = (lock_cnt_q == 8'hFF) ? lock_cnt_q : (lock_cnt_q + 8'd1);
                    locked_d   = (lock_cnt_d >= LOCK_CNT);
                end
`endif
            end
            S_OUT: begin
                corr_d = corr_q;
            end
            default: begin
                corr_d = corr_q;
            end
        endcase
    end

    // Datapath and registered outputs; reset discards any in-flight update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q        <= '0;
            kp_q         <= '0;
            ki_q         <= '0;
            p_q          <= 34'sd0;
            i_q          <= 34'sd0;
            integ_q      <= 32'sd0;
            corr_q       <= FCW_NOM;
            corr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            err_q        <= err_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            p_q          <= p_d;
            i_q          <= i_d;
            integ_q      <= integ_d;
            corr_q       <= corr_d;
            corr_valid_q <= corr_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef CARRIER_LOOP_FILTER_LOCK_DET_EN
    // Lock detector counter and flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_cnt_q <= 8'd0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign locked = locked_q;
`endif

    assign correction = corr_q;
    assign corr_valid = corr_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
